// File: rtl/text_pkg.sv
// ----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text-line renderer:
//   GLYPH_W / GLYPH_H : glyph cell size in pixels (8 wide, 16 tall)
//   ascii_t           : 7-bit character code
//   ASCII_SPACE       : code loaded into every buffer cell on reset
//   blink_phase_t     : cursor blink phase (off = not inverted)
//   rom_addr()        : pattern ROM address for a glyph row, {code, row}
// ----------------------------------------------------------------------------
package text_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    typedef logic [6:0] ascii_t;

    localparam ascii_t ASCII_SPACE = 7'h20;

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } blink_phase_t;

    // The pattern ROM stores 16 consecutive rows per glyph, so the code
    // selects the glyph block and the row selects the byte inside it.
    function automatic logic [10:0] rom_addr(ascii_t code, logic [3:0] row);
        return {code, row};
    endfunction

endpackage

// File: rtl/cursor_blink.sv
// ----------------------------------------------------------------------------
// cursor_blink
// Counts frame-start pulses and toggles the blink phase every BLINK_FRAMES
// pulses. While the cursor is disabled the counter and phase are held at 0,
// so enabling the cursor always restarts a full non-inverted half-period.
// Ports:
//   clk_i          pixel clock
//   rst_i          asynchronous active-high reset
//   enable_i       cursor enable; low holds counter and phase cleared
//   frame_start_i  one-cycle pulse at the start of each frame
//   blink_phase_o  1 while the cursor cell should be drawn inverted
// ----------------------------------------------------------------------------
module cursor_blink
    import text_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic frame_start_i,
    output logic blink_phase_o
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt;
    blink_phase_t     phase;

    // Frame counter and phase toggle. The pulse that lands on the last
    // count of a half-period wraps the counter and flips the phase, so the
    // phase changes once every BLINK_FRAMES pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt <= '0;
            phase     <= PHASE_OFF;
        end else if (!enable_i) begin
            frame_cnt <= '0;
            phase     <= PHASE_OFF;
        end else if (frame_start_i) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= '0;
                phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_phase_o = (phase == PHASE_ON);

endmodule

// File: rtl/text_line_ctrl.sv
// ----------------------------------------------------------------------------
// text_line_ctrl
// Renders one line of NUM_CHARS ASCII characters into the VGA pixel stream.
// Stage 0 maps the pixel coordinate to a buffer cell, glyph row and glyph
// column and reads the character code; stage 1 drives the external async
// pattern ROM and picks the glyph bit. Output latency is a fixed 2 cycles.
// Ports:
//   clk_i, rst_i      pixel clock, asynchronous active-high reset
//   wr_en_i           character buffer write strobe
//   wr_idx_i          buffer cell to write
//   wr_char_i         ASCII code to write
//   cursor_en_i       cursor enable
//   cursor_idx_i      cursor cell
//   frame_start_i     one-cycle pulse at each frame start (blink timing)
//   video_on_i        active-video flag aligned with x_i / y_i
//   x_i, y_i          current pixel column / row
//   rom_addr_o        pattern ROM address {code, row}
//   rom_data_i        pattern ROM row data, same cycle as rom_addr_o
//   pix_o             text pixel, 1 = foreground
//   pix_valid_o       video_on_i delayed to line up with pix_o
// ----------------------------------------------------------------------------
module text_line_ctrl
    import text_pkg::*;
#(
    parameter int NUM_CHARS    = 16,
    parameter int X0           = 0,
    parameter int Y0           = 0,
    parameter int ROM_AW       = 11,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(NUM_CHARS)-1:0] wr_idx_i,
    input  logic [6:0]                   wr_char_i,
    input  logic                         cursor_en_i,
    input  logic [$clog2(NUM_CHARS)-1:0] cursor_idx_i,
    input  logic                         frame_start_i,
    input  logic                         video_on_i,
    input  logic [9:0]                   x_i,
    input  logic [9:0]                   y_i,
    output logic [ROM_AW-1:0]            rom_addr_o,
    input  logic [7:0]                   rom_data_i,
    output logic                         pix_o,
    output logic                         pix_valid_o
);

    localparam int          CW    = $clog2(NUM_CHARS);
    localparam logic [10:0] WIN_W = 11'(NUM_CHARS * GLYPH_W);
    localparam logic [10:0] WIN_H = 11'(GLYPH_H);

    ascii_t          char_buf [NUM_CHARS];

    logic [10:0]     dx;
    logic [10:0]     dy;
    logic            in_win;
    logic [CW-1:0]   col;
    logic [2:0]      bit_sel;
    logic [3:0]      row;
    ascii_t          code_rd;
    logic            blink_phase;
    logic            cursor_hit;

    ascii_t          code_q;
    logic [3:0]      row_q;
    logic [2:0]      bit_q;
    logic            in_win_q;
    logic            cursor_hit_q;
    logic            video_on_q;

    // Window offsets are taken at 11 bits so a coordinate left of X0 or above
    // Y0 borrows into bit 10; such a value is far above the window size and
    // is rejected by the unsigned compare, with the borrow bit also checked
    // explicitly.
    assign dx      = {1'b0, x_i} - 11'(X0);
    assign dy      = {1'b0, y_i} - 11'(Y0);
    assign in_win  = video_on_i & ~dx[10] & ~dy[10] & (dx < WIN_W) & (dy < WIN_H);
    assign col     = dx[3 +: CW];
    assign bit_sel = dx[2:0];
    assign row     = dy[3:0];
    assign code_rd = char_buf[col];

    cursor_blink #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_cursor_blink (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (cursor_en_i),
        .frame_start_i (frame_start_i),
        .blink_phase_o (blink_phase)
    );

    assign cursor_hit = cursor_en_i & (col == cursor_idx_i) & blink_phase;

    // Character buffer. Reads are combinational, so a stage-0 read of the
    // cell being written in the same cycle still sees the old code.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                char_buf[i] <= ASCII_SPACE;
            end
        end else if (wr_en_i) begin
            char_buf[wr_idx_i] <= wr_char_i;
        end
    end

    // Stage 0 registers: everything stage 1 needs to address the ROM and
    // choose the glyph bit. The code register resets to a space so the ROM
    // address sits on the blank glyph while held in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            code_q       <= ASCII_SPACE;
            row_q        <= '0;
            bit_q        <= '0;
            in_win_q     <= 1'b0;
            cursor_hit_q <= 1'b0;
            video_on_q   <= 1'b0;
        end else begin
            code_q       <= code_rd;
            row_q        <= row;
            bit_q        <= bit_sel;
            in_win_q     <= in_win;
            cursor_hit_q <= cursor_hit;
            video_on_q   <= video_on_i;
        end
    end

    assign rom_addr_o = ROM_AW'(rom_addr(code_q, row_q));

    // Stage 1 registers: bit 7 of a ROM row is the leftmost pixel of the
    // glyph. The cursor inverts the cell, and nothing outside the window is
    // ever drawn, not even an inverted cursor.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_o       <= 1'b0;
            pix_valid_o <= 1'b0;
        end else begin
            pix_o       <= in_win_q & (rom_data_i[3'd7 - bit_q] ^ cursor_hit_q);
            pix_valid_o <= video_on_q;
        end
    end

endmodule
